// File: rtl/ultrasonic_scheduler_if.sv
// ultrasonic_scheduler_if
//   Bundles the control, sensor-pin and result signals of the ultrasonic
//   scheduler. The slave modport is the scheduler's view; the master modport
//   is the view of whatever drives it (controller logic or a testbench).
//   enable, stop, sensor_mask, echo        : into the scheduler
//   trigger, busy, cur_sensor              : sequencing status and sensor pins
//   dist_cm, dist_id, dist_valid,
//   timeout_flag                           : tagged measurement result
interface ultrasonic_scheduler_if #(
    parameter int N_SENSORS = 2
);
    logic                 enable;
    logic                 stop;
    logic [N_SENSORS-1:0] sensor_mask;
    logic [N_SENSORS-1:0] echo;
    logic [N_SENSORS-1:0] trigger;
    logic                 busy;
    logic [2:0]           cur_sensor;
    logic [15:0]          dist_cm;
    logic [2:0]           dist_id;
    logic                 dist_valid;
    logic                 timeout_flag;

    modport slave (
        input  enable, stop, sensor_mask, echo,
        output trigger, busy, cur_sensor, dist_cm, dist_id, dist_valid, timeout_flag
    );

    modport master (
        output enable, stop, sensor_mask, echo,
        input  trigger, busy, cur_sensor, dist_cm, dist_id, dist_valid, timeout_flag
    );
endinterface

// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler
//   Shares one HC-SR04 style ranging sequence across N_SENSORS sensors.
//   Sensors are served round-robin over sensor_mask, one at a time:
//   trigger pulse, wait for echo rise, time the echo in cm, report, guard.
//   Ports:
//     clk   : system clock
//     reset : asynchronous active-high reset
//     bus   : ultrasonic_scheduler_if.slave (control in, echo in,
//             trigger out, status out, tagged distance result out)
module ultrasonic_scheduler #(
    parameter int N_SENSORS    = 2,
    parameter int TRIG_CYCLES  = 500,
    parameter int CYC_PER_CM   = 2900,
    parameter int MAX_CM       = 400,
    parameter int RISE_TIMEOUT = 1500000,
    parameter int GUARD_CYCLES = 500000
) (
    input logic                    clk,
    input logic                    reset,
    ultrasonic_scheduler_if.slave  bus
);

    // One shared cycle counter serves TRIG, WAIT_RISE, MEASURE and GUARD,
    // so it is sized for the largest of their limits.
    localparam int M1      = (TRIG_CYCLES  > CYC_PER_CM)   ? TRIG_CYCLES  : CYC_PER_CM;
    localparam int M2      = (RISE_TIMEOUT > GUARD_CYCLES) ? RISE_TIMEOUT : GUARD_CYCLES;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, REPORT, GUARD
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [15:0]          r_cm;
    logic [2:0]           r_cur;
    logic [2:0]           r_last;
    logic [N_SENSORS-1:0] r_trig;
    logic [15:0]          r_dist;
    logic [2:0]           r_dist_id;
    logic                 r_dv;
    logic                 r_tf;
    logic [N_SENSORS-1:0] r_echo_m;
    logic [N_SENSORS-1:0] r_echo_s;

    logic                 w_echo_cur;
    logic                 w_found;
    logic [2:0]           w_pick;
    int                   w_best;
    int                   w_off;
    logic [15:0]          w_cm_nxt;
    logic                 w_cyc_wrap;

    // Synchronized echo of the sensor currently being served.
    always_comb begin
        w_echo_cur = 1'b0;
        for (int i = 0; i < N_SENSORS; i++)
            if (r_cur == 3'(i)) w_echo_cur = r_echo_s[i];
    end

    // Round-robin pick: the enabled sensor with the smallest forward distance
    // from the last-served index (distance N means the same sensor again).
    always_comb begin
        w_found = |bus.sensor_mask;
        w_pick  = r_last;
        w_best  = N_SENSORS + 1;
        w_off   = 0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (bus.sensor_mask[i]) begin
                w_off = (i > int'(r_last)) ? (i - int'(r_last))
                                           : (i + N_SENSORS - int'(r_last));
                if (w_off < w_best) begin
                    w_best = w_off;
                    w_pick = 3'(i);
                end
            end
        end
    end

    // cm value including this cycle, so the echo-fall cycle is counted too
    // and the result is floor(echo_width / CYC_PER_CM).
    assign w_cyc_wrap = (r_cnt == CW'(CYC_PER_CM - 1));
    assign w_cm_nxt   = w_cyc_wrap ? r_cm + 16'd1 : r_cm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_cm      <= '0;
            r_cur     <= '0;
            r_last    <= 3'(N_SENSORS - 1);   // first search lands on sensor 0
            r_trig    <= '0;
            r_dist    <= '0;
            r_dist_id <= '0;
            r_dv      <= 1'b0;
            r_tf      <= 1'b0;
            r_echo_m  <= '0;
            r_echo_s  <= '0;
        end else begin
            r_echo_m <= bus.echo;
            r_echo_s <= r_echo_m;
            if (bus.stop) begin
                // Abort wins over everything; the round-robin pointer survives.
                r_state <= IDLE;
                r_trig  <= '0;
                r_cnt   <= '0;
                r_cm    <= '0;
                r_dist  <= '0;
                r_dv    <= 1'b0;
                r_tf    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.enable && w_found) r_state <= SELECT;
                    end
                    SELECT: begin
                        if (bus.enable && w_found) begin
                            r_cur   <= w_pick;
                            r_last  <= w_pick;
                            r_trig  <= N_SENSORS'(1) << w_pick;
                            r_cnt   <= '0;
                            r_state <= TRIG;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    TRIG: begin
                        if (r_cnt == CW'(TRIG_CYCLES - 1)) begin
                            r_trig  <= '0;
                            r_cnt   <= '0;
                            r_state <= WAIT_RISE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    WAIT_RISE: begin
                        if (w_echo_cur) begin
                            r_cnt   <= '0;
                            r_cm    <= '0;
                            r_state <= MEASURE;
                        end else if (r_cnt == CW'(RISE_TIMEOUT - 1)) begin
                            r_dist    <= 16'hFFFF;
                            r_dist_id <= r_cur;
                            r_dv      <= 1'b1;
                            r_tf      <= 1'b1;
                            r_state   <= REPORT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (!w_echo_cur) begin
                            r_dist    <= w_cm_nxt;
                            r_dist_id <= r_cur;
                            r_dv      <= 1'b1;
                            r_tf      <= 1'b0;
                            r_state   <= REPORT;
                        end else if (w_cm_nxt == 16'(MAX_CM)) begin
                            r_dist    <= 16'hFFFF;
                            r_dist_id <= r_cur;
                            r_dv      <= 1'b1;
                            r_tf      <= 1'b1;
                            r_state   <= REPORT;
                        end else begin
                            r_cnt <= w_cyc_wrap ? '0 : r_cnt + 1'b1;
                            r_cm  <= w_cm_nxt;
                        end
                    end
                    REPORT: begin
                        r_dv    <= 1'b0;
                        r_tf    <= 1'b0;
                        r_cnt   <= '0;
                        r_cm    <= '0;
                        r_state <= GUARD;
                    end
                    GUARD: begin
                        if (r_cnt == CW'(GUARD_CYCLES - 1)) begin
                            r_cnt   <= '0;
                            r_state <= SELECT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.trigger      = r_trig;
    assign bus.busy         = (r_state != IDLE);
    assign bus.cur_sensor   = r_cur;
    assign bus.dist_cm      = r_dist;
    assign bus.dist_id      = r_dist_id;
    assign bus.dist_valid   = r_dv;
    assign bus.timeout_flag = r_tf;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// tb_ultrasonic_scheduler
//   Drives the scheduler with scripted sensor echoes and checks tagged
//   results against an expected-result queue, plus trigger timing,
//   echo-fall latency, stop and asynchronous reset behaviour.
module tb_ultrasonic_scheduler;
    localparam int N   = 2;
    localparam int TRG = 5;
    localparam int CPC = 10;
    localparam int MXC = 20;
    localparam int RTO = 100;
    localparam int GRD = 50;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ultrasonic_scheduler_if #(.N_SENSORS(N)) bus();

    ultrasonic_scheduler #(
        .N_SENSORS(N), .TRIG_CYCLES(TRG), .CYC_PER_CM(CPC),
        .MAX_CM(MXC), .RISE_TIMEOUT(RTO), .GUARD_CYCLES(GRD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // {dist_id[2:0], dist_cm[15:0], timeout_flag}
    logic [19:0] exp_q[$];

    int       cyc = 0;
    int       last_rep = 0;
    bit       have_rep = 0;
    int       ov_viol = 0;
    int       gap_viol = 0;
    int       dv_viol = 0;
    logic [N-1:0] prev_trig = '0;
    logic     prev_dv = 1'b0;

    // Result monitor and pin-level invariants.
    always @(negedge clk) begin
        logic [19:0] e;
        cyc++;
        if (bus.dist_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("dist_id", bus.dist_id, e[19:17]);
                chk("dist_cm", bus.dist_cm, e[16:1]);
                chk("timeout_flag", bus.timeout_flag, e[0]);
            end
            if (prev_dv === 1'b1) dv_viol++;
            last_rep = cyc;
            have_rep = 1;
        end
        if ($countones(bus.trigger) > 1) ov_viol++;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i != j && bus.trigger[i] === 1'b1 && bus.echo[j] === 1'b1) ov_viol++;
        if (have_rep && ((bus.trigger & ~prev_trig) != '0) && (cyc - last_rep < GRD)) gap_viol++;
        prev_trig = bus.trigger;
        prev_dv   = bus.dist_valid;
    end

    // One measurement on sensor id: echo rises dly cycles after trigger ends
    // and stays high width cycles (width 0 = never rises).
    task automatic measure(input int id, input int dly, input int width,
                           input bit clr_mask, input bit drop_en);
        int          n;
        bit          rep;
        logic [15:0] ed;
        bit          tf;
        n = 0;
        while (bus.trigger[id] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (bus.trigger[id] !== 1'b1) begin
            chk("trig_seen", 0, 1);
            return;
        end
        if (drop_en) bus.enable = 1'b0;
        n = 0;
        while (bus.trigger[id] === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("trig_len", n, TRG);
        if (width == 0) begin
            exp_q.push_back({3'(id), 16'hFFFF, 1'b1});
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.dist_valid !== 1'b1 && n < 300);
            chk("rise_timeout_lat", n, RTO);
            return;
        end
        tf = (width > MXC * CPC);
        ed = tf ? 16'hFFFF : 16'(width / CPC);
        exp_q.push_back({3'(id), ed, tf});
        repeat (dly) @(negedge clk);
        bus.echo[id] = 1'b1;
        rep = 0;
        for (int k = 0; k < width; k++) begin
            @(negedge clk);
            if (bus.dist_valid === 1'b1) rep = 1;
            if (clr_mask && k == width / 2) bus.sensor_mask = 2'b01;
        end
        bus.echo[id] = 1'b0;
        if (tf) begin
            chk("ovf_during_echo", rep, 1);
        end else begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.dist_valid !== 1'b1 && n < 50);
            chk("fall_to_valid_lat", n, 3);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.stop        = 1'b0;
        bus.sensor_mask = '0;
        bus.echo        = '0;
        repeat (3) @(negedge clk);
        chk("rst_trigger", bus.trigger, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cur", bus.cur_sensor, 0);
        chk("rst_dist", bus.dist_cm, 0);
        chk("rst_id", bus.dist_id, 0);
        chk("rst_dv", bus.dist_valid, 0);
        chk("rst_tf", bus.timeout_flag, 0);
        reset = 1'b0;

        // Single sensor, 73-cycle echo -> 7 cm.
        bus.sensor_mask = 2'b01;
        bus.enable      = 1'b1;
        measure(0, 20, 73, 0, 0);
        // No echo -> timeout, then a retrigger after guard.
        measure(0, 0, 0, 0, 0);
        measure(0, 5, 40, 0, 0);

        // Two sensors alternate.
        bus.sensor_mask = 2'b11;
        measure(1, 10, 55, 0, 0);
        measure(0, 10, 30, 0, 0);
        measure(1, 10, 55, 0, 0);
        measure(0, 10, 30, 0, 0);

        // Drop sensor 1 from the mask mid-measurement.
        measure(1, 10, 55, 1, 0);
        measure(0, 10, 30, 0, 0);
        measure(0, 10, 30, 0, 0);

        // Echo stuck high -> out of range; schedule then stops on enable=0.
        measure(0, 10, 300, 0, 1);
        chk("idle_after_en_low", bus.busy, 0);
        bus.enable = 1'b1;
        measure(0, 10, 30, 0, 0);

        // Stop mid-MEASURE.
        n = 0;
        while (bus.trigger[0] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("stop_trig_seen", bus.trigger[0], 1);
        while (bus.trigger[0] === 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        bus.echo[0] = 1'b1;
        repeat (15) @(negedge clk);
        chk("pre_stop_busy", bus.busy, 1);
        bus.stop = 1'b1;
        @(negedge clk);
        chk("stop_trigger", bus.trigger, 0);
        chk("stop_dist", bus.dist_cm, 0);
        chk("stop_busy", bus.busy, 0);
        chk("stop_dv", bus.dist_valid, 0);
        bus.echo[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("stop_hold_idle", bus.busy, 0);
        bus.stop = 1'b0;

        // Asynchronous reset mid-TRIG.
        n = 0;
        while (bus.trigger[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_trig_seen", bus.trigger[0], 1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_trigger", bus.trigger, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_cur", bus.cur_sensor, 0);
        chk("async_rst_dist", bus.dist_cm, 0);
        chk("async_rst_id", bus.dist_id, 0);
        chk("async_rst_dv", bus.dist_valid, 0);
        bus.enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_idle", bus.busy, 0);

        chk("trigger_overlap", ov_viol, 0);
        chk("guard_gap", gap_viol, 0);
        chk("dv_one_cycle", dv_viol, 0);
        chk("results_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
